mem_arbiter: RTL and testbench

- Shares the single-port, word-addressed system memory between two bus masters.
  - Master 0: the CPU control unit.
  - Master 1: a DMA, debug or video requester.
- Each master uses a request/grant handshake. Every cycle, at most one transfer is issued to memory.
- Read data returns to the owning master after a fixed memory latency.
- A lock input lets a master (e.g. the CPU during an interrupt push) issue back-to-back accesses without interleaving.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter_rd_return_pipe.sv | 31 +++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    localparam logic M_CPU  = 1'b0;
    localparam logic M_AUX  = 1'b1;
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // Tag carried alongside an outstanding read until its data returns.
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Per-master request/grant bus between a requester and the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, rw, addr, wdata, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, rw, addr, wdata, lock,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter_rd_return_pipe.sv
// Delay line of DEPTH stages carrying {valid, owner} for each read issue.
module mem_arbiter_rd_return_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);
    rd_tag_t chain [DEPTH+1];

    assign chain[0] = tag_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        rd_tag_t tag_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                tag_q <= '0;
            end else begin
                tag_q <= chain[gi];
            end
        end

        assign chain[gi+1] = tag_q;
    end

    assign tag_o = chain[DEPTH];
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with bus lock sharing one single-port memory between
// the CPU (master 0) and an auxiliary requester (master 1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      m0_if,
    mem_arbiter_if.slave      m1_if,
    output logic              mem_en_o,
    output logic              mem_rw_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              gnt0, gnt1;
    logic [ADDR_W-1:0] sel_addr;
    rd_tag_t           issue_tag, ret_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARB;
            last_q  <= M_AUX;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        state_d = state_q;
        last_d  = last_q;

        case (state_q)
            ST_ARB: begin
                if (m0_if.req && m1_if.req) begin
                    gnt0 = (last_q == M_AUX);
                    gnt1 = (last_q == M_CPU);
                end else begin
                    gnt0 = m0_if.req;
                    gnt1 = m1_if.req;
                end
            end
            ST_LOCK0: gnt0 = m0_if.req;
            ST_LOCK1: gnt1 = m1_if.req;
            default:  state_d = ST_ARB;
        endcase

        // Grants are combinational, so they must be masked while reset is held.
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        if (gnt0) begin
            last_d  = M_CPU;
            state_d = m0_if.lock ? ST_LOCK0 : ST_ARB;
        end else if (gnt1) begin
            last_d  = M_AUX;
            state_d = m1_if.lock ? ST_LOCK1 : ST_ARB;
        end else if (state_q == ST_LOCK0 && !m0_if.lock) begin
            state_d = ST_ARB;
        end else if (state_q == ST_LOCK1 && !m1_if.lock) begin
            state_d = ST_ARB;
        end
    end

    assign sel_addr    = gnt1 ? m1_if.addr : m0_if.addr;
    assign mem_en_o    = gnt0 | gnt1;
    assign mem_rw_o    = gnt1 ? m1_if.rw : m0_if.rw;
    assign mem_addr_o  = sel_addr & ~ADDR_W'(3);
    assign mem_wdata_o = gnt1 ? m1_if.wdata : m0_if.wdata;

    assign issue_tag.valid = mem_en_o && (mem_rw_o == MEM_RD);
    assign issue_tag.owner = gnt1 ? M_AUX : M_CPU;

    mem_arbiter_rd_return_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_rd_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (issue_tag),
        .tag_o (ret_tag)
    );

    assign m0_if.gnt    = gnt0;
    assign m1_if.gnt    = gnt1;
    assign m0_if.rvalid = !reset && ret_tag.valid && (ret_tag.owner == M_CPU);
    assign m1_if.rvalid = !reset && ret_tag.valid && (ret_tag.owner == M_AUX);
    assign m0_if.rdata  = mem_rdata_i;
    assign m1_if.rdata  = mem_rdata_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (read latency 1, 2, 3) share one stimulus,
// each with its own behavioural memory.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NI = 3;
    localparam logic [NI-1:0] ALL  = '1;
    localparam logic [NI-1:0] NONE = '0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0, rw0, lock0, req1, rw1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic [NI-1:0] g0, g1, rv0, rv1, men, mrw;
    logic [AW-1:0] maddr [NI];
    logic [DW-1:0] rd0   [NI];
    logic [DW-1:0] rd1   [NI];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
        mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();
        logic          en, rw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rdata;
        logic [DW-1:0] mem    [0:1023];
        logic [DW-1:0] pipe_q [0:gi];

        assign m0_bus.req   = req0;
        assign m0_bus.rw    = rw0;
        assign m0_bus.addr  = addr0;
        assign m0_bus.wdata = wdata0;
        assign m0_bus.lock  = lock0;
        assign m1_bus.req   = req1;
        assign m1_bus.rw    = rw1;
        assign m1_bus.addr  = addr1;
        assign m1_bus.wdata = wdata1;
        assign m1_bus.lock  = lock1;

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(gi+1)) dut (
            .clk         (clk),
            .reset       (reset),
            .m0_if       (m0_bus),
            .m1_if       (m1_bus),
            .mem_en_o    (en),
            .mem_rw_o    (rw),
            .mem_addr_o  (a),
            .mem_wdata_o (wd),
            .mem_rdata_i (rdata)
        );

        always @(posedge clk) begin
            if (en && rw) mem[a[11:2]] <= wd;
            pipe_q[0] <= mem[a[11:2]];
            for (int k = 1; k <= gi; k++) pipe_q[k] <= pipe_q[k-1];
        end
        assign rdata = pipe_q[gi];

        assign g0[gi]    = m0_bus.gnt;
        assign g1[gi]    = m1_bus.gnt;
        assign rv0[gi]   = m0_bus.rvalid;
        assign rv1[gi]   = m1_bus.rvalid;
        assign men[gi]   = en;
        assign mrw[gi]   = rw;
        assign maddr[gi] = a;
        assign rd0[gi]   = m0_bus.rdata;
        assign rd1[gi]   = m1_bus.rdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
        req0 = r; rw0 = w; addr0 = a; wdata0 = d; lock0 = l;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
        req1 = r; rw1 = w; addr1 = a; wdata1 = d; lock1 = l;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [6:0] e_g0, e_g1, e_rv0, e_rv1;

    initial begin
        reset = 1'b1;
        drive0(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        drive1(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        next_cycle();
        next_cycle();
        settle();
        check("rst_gnt0",   32'(g0), 32'(NONE));
        check("rst_gnt1",   32'(g1), 32'(NONE));
        check("rst_mem_en", 32'(men), 32'(NONE));
        check("rst_rvalid", 32'(rv0 | rv1), 32'(NONE));

        // Continuous contention from reset; latency-3 instance shows returns.
        e_g0  = 7'b0000101;
        e_g1  = 7'b0001010;
        e_rv0 = 7'b0101000;
        e_rv1 = 7'b1010000;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            if (k == 0) reset = 1'b0;
            req0 = (k < 4);
            req1 = (k < 4);
            settle();
            check("rr_gnt0",   32'(g0),  32'({NI{e_g0[k]}}));
            check("rr_gnt1",   32'(g1),  32'({NI{e_g1[k]}}));
            check("rr_mem_en", 32'(men), 32'({NI{e_g0[k] | e_g1[k]}}));
            check("rr_l3_rvalid0", 32'(rv0[2]), 32'(e_rv0[k]));
            check("rr_l3_rvalid1", 32'(rv1[2]), 32'(e_rv1[k]));
        end

        // Preload 0x104 through master 1.
        next_cycle();
        drive1(1'b1, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0);
        settle();
        check("preload_gnt1", 32'(g1), 32'(ALL));

        // Locked pair of CPU writes against a continuous master-1 request.
        next_cycle();
        drive0(1'b1, 1'b1, 32'h1FFC, 32'h11, 1'b1);
        drive1(1'b1, 1'b0, 32'h300, 32'h0, 1'b0);
        settle();
        check("lock_w1_gnt0", 32'(g0), 32'(ALL));
        check("lock_w1_gnt1", 32'(g1), 32'(NONE));
        check("lock_w1_addr", maddr[0], 32'h1FFC);
        check("lock_w1_rw",   32'(mrw), 32'(ALL));
        next_cycle();
        drive0(1'b1, 1'b1, 32'h1FF8, 32'h22, 1'b0);
        settle();
        check("lock_w2_gnt0", 32'(g0), 32'(ALL));
        check("lock_w2_gnt1", 32'(g1), 32'(NONE));
        check("lock_w2_addr", maddr[0], 32'h1FF8);
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("lock_after_gnt1", 32'(g1), 32'(ALL));
        check("lock_after_gnt0", 32'(g0), 32'(NONE));

        // Lock held by an idle owner keeps master 1 out until lock drops.
        next_cycle();
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive0(1'b1, 1'b1, 32'h10, 32'h33, 1'b1);
        settle();
        check("idle_lock_gnt0", 32'(g0), 32'(ALL));
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        drive1(1'b1, 1'b0, 32'h300, 32'h0, 1'b0);
        settle();
        check("idle_lock_hold", 32'(g1), 32'(NONE));
        next_cycle();
        lock0 = 1'b0;
        settle();
        check("idle_lock_drop_cycle", 32'(g1), 32'(NONE));
        next_cycle();
        settle();
        check("idle_lock_released", 32'(g1), 32'(ALL));

        // Solo CPU read of an unaligned address.
        next_cycle();
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive0(1'b1, 1'b0, 32'h106, 32'h0, 1'b0);
        settle();
        check("solo_gnt0",   32'(g0), 32'(ALL));
        check("solo_addr",   maddr[0], 32'h104);
        check("solo_mem_en", 32'(men), 32'(ALL));
        check("solo_rw",     32'(mrw), 32'(NONE));
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("solo_l1_rvalid0", 32'(rv0[0]), 32'h1);
        check("solo_l1_rdata0",  rd0[0], 32'hDEADBEEF);
        check("solo_l1_rvalid1", 32'(rv1[0]), 32'h0);
        check("solo_l2_early",   32'(rv0[1]), 32'h0);
        next_cycle();
        settle();
        check("solo_l1_pulse",   32'(rv0[0]), 32'h0);
        check("solo_l2_rvalid0", 32'(rv0[1]), 32'h1);
        check("solo_l2_rdata0",  rd0[1], 32'hDEADBEEF);

        // Write by master 1 visible to a CPU read in the next cycle.
        next_cycle();
        drive1(1'b1, 1'b1, 32'h200, 32'h55AA55AA, 1'b0);
        settle();
        check("wr_gnt1", 32'(g1), 32'(ALL));
        next_cycle();
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive0(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        settle();
        check("rd_gnt0", 32'(g0), 32'(ALL));
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("wr_rd_rvalid", 32'(rv0[0]), 32'h1);
        check("wr_rd_rdata",  rd0[0], 32'h55AA55AA);

        // Reset one cycle after a read issue discards the read.
        next_cycle();
        drive0(1'b1, 1'b0, 32'h104, 32'h0, 1'b0);
        settle();
        check("mid_rst_issue", 32'(g0), 32'(ALL));
        next_cycle();
        reset = 1'b1;
        drive1(1'b1, 1'b0, 32'h300, 32'h0, 1'b0);
        settle();
        check("mid_rst_gnt",    32'(g0 | g1), 32'(NONE));
        check("mid_rst_mem_en", 32'(men), 32'(NONE));
        check("mid_rst_rvalid", 32'(rv0 | rv1), 32'(NONE));
        next_cycle();
        reset = 1'b0;
        settle();
        check("post_rst_l2_drop", 32'(rv0[1]), 32'h0);
        check("post_rst_gnt0",    32'(g0), 32'(ALL));
        check("post_rst_gnt1",    32'(g1), 32'(NONE));
        next_cycle();
        drive0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        check("post_rst_l3_drop", 32'(rv0[2:1]), 32'h0);
        check("post_rst_rvalid1", 32'(rv1), 32'(NONE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
